// File: rtl/exe_stage_md.sv
// EX stage: ALU, full-width multiplier, iterative restoring divider and the
// data-SRAM request. The divider holds the stage for XLEN/DIV_STEP cycles.
module exe_stage_md #(
   parameter int XLEN     = 32,
   parameter int DIV_STEP = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_to_ex_valid,
   output logic              ex_allowin,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_src1,
   input  logic [XLEN-1:0]   id_src2,
   input  logic [XLEN-1:0]   id_rkd,
   input  logic [11:0]       id_alu_op,
   input  logic [2:0]        id_cls,
   input  logic [1:0]        id_md_op,
   input  logic [1:0]        id_size,
   input  logic              id_rf_we,
   input  logic [4:0]        id_rf_waddr,
   input  logic              mem_allowin,
   output logic              ex_to_mem_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_result,
   output logic              ex_rf_we,
   output logic [4:0]        ex_rf_waddr,
   output logic              ex_is_load,
   output logic              ex_ale,
   output logic              ex_fwd_we,
   output logic [4:0]        ex_fwd_addr,
   output logic              ex_fwd_ready,
   input  logic              ex_flush,
   output logic              data_sram_en,
   output logic [XLEN/8-1:0] data_sram_we,
   output logic [XLEN-1:0]   data_sram_addr,
   output logic [XLEN-1:0]   data_sram_wdata
);
   localparam int STEPS = XLEN / DIV_STEP;
   localparam int NB    = XLEN / 8;
   localparam int LB    = $clog2(NB);
   localparam int SB    = $clog2(XLEN);
   localparam int CW    = $clog2(STEPS) + 1;

   localparam logic [2:0] CLS_LD  = 3'd1;
   localparam logic [2:0] CLS_ST  = 3'd2;
   localparam logic [2:0] CLS_MUL = 3'd3;
   localparam logic [2:0] CLS_DIV = 3'd4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] src1;
      logic [XLEN-1:0] src2;
      logic [XLEN-1:0] rkd;
      logic [11:0]     alu_op;
      logic [2:0]      cls;
      logic [1:0]      md_op;
      logic [1:0]      size;
      logic            rf_we;
      logic [4:0]      rf_waddr;
   } ex_fields_t;

   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

   ex_fields_t       f_q, f_d;
   logic             ex_valid_q, ex_valid_d;
   div_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [XLEN:0]    rem_q, rem_d;
   logic [XLEN-1:0]  quo_q, quo_d;
   logic [XLEN-1:0]  dvs_q, dvs_d;
   logic             qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d;

   logic             is_ld, is_st, is_mul, is_div, ready_go;
   logic [XLEN-1:0]  alu_res, mul_res, div_res, sel_res;
   logic [SB-1:0]    shamt;
   logic [2*XLEN-1:0] mul_a, mul_b, prod;
   logic             a_neg, b_neg;
   logic [XLEN-1:0]  a_mag, b_mag;
   logic [XLEN:0]    step_r;
   logic [XLEN-1:0]  step_q;
   logic             mis, ale_raw;
   logic [NB-1:0]    we_base, st_mask;
   logic [XLEN-1:0]  st_wdata;

   // ---------------- handshake and field latch ----------------
   always_comb begin
      is_ld    = (f_q.cls == CLS_LD);
      is_st    = (f_q.cls == CLS_ST);
      is_mul   = (f_q.cls == CLS_MUL);
      is_div   = (f_q.cls == CLS_DIV);
      ready_go = ~is_div | (state_q == DIV_DONE);
      ex_allowin      = ~ex_valid_q | (ready_go & mem_allowin);
      ex_to_mem_valid = ex_valid_q & ready_go & ~ex_flush;

      ex_valid_d = ex_valid_q;
      if (ex_flush)        ex_valid_d = 1'b0;
      else if (ex_allowin) ex_valid_d = id_to_ex_valid;

      f_d = f_q;
      if (id_to_ex_valid && ex_allowin)
         f_d = '{pc: id_pc, src1: id_src1, src2: id_src2, rkd: id_rkd,
                 alu_op: id_alu_op, cls: id_cls, md_op: id_md_op,
                 size: id_size, rf_we: id_rf_we, rf_waddr: id_rf_waddr};
   end

   // ---------------- ALU (one-hot AND-OR select) ----------------
   always_comb begin
      shamt   = f_q.src2[SB-1:0];
      alu_res = ({XLEN{f_q.alu_op[0]}}  & (f_q.src1 + f_q.src2))
              | ({XLEN{f_q.alu_op[1]}}  & (f_q.src1 - f_q.src2))
              | ({XLEN{f_q.alu_op[2]}}  & {{(XLEN-1){1'b0}}, $signed(f_q.src1) < $signed(f_q.src2)})
              | ({XLEN{f_q.alu_op[3]}}  & {{(XLEN-1){1'b0}}, f_q.src1 < f_q.src2})
              | ({XLEN{f_q.alu_op[4]}}  & (f_q.src1 & f_q.src2))
              | ({XLEN{f_q.alu_op[5]}}  & ~(f_q.src1 | f_q.src2))
              | ({XLEN{f_q.alu_op[6]}}  & (f_q.src1 | f_q.src2))
              | ({XLEN{f_q.alu_op[7]}}  & (f_q.src1 ^ f_q.src2))
              | ({XLEN{f_q.alu_op[8]}}  & (f_q.src1 << shamt))
              | ({XLEN{f_q.alu_op[9]}}  & (f_q.src1 >> shamt))
              | ({XLEN{f_q.alu_op[10]}} & $unsigned($signed(f_q.src1) >>> shamt))
              | ({XLEN{f_q.alu_op[11]}} & f_q.src2);
   end

   // ---------------- multiplier ----------------
   always_comb begin
      mul_a   = {{XLEN{f_q.md_op[0] & f_q.src1[XLEN-1]}}, f_q.src1};
      mul_b   = {{XLEN{f_q.md_op[0] & f_q.src2[XLEN-1]}}, f_q.src2};
      prod    = mul_a * mul_b;
      mul_res = f_q.md_op[1] ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
   end

   // ---------------- divider: magnitudes in, signs fixed at the output ----------------
   always_comb begin
      a_neg = f_q.md_op[0] & f_q.src1[XLEN-1];
      b_neg = f_q.md_op[0] & f_q.src2[XLEN-1];
      a_mag = a_neg ? -f_q.src1 : f_q.src1;
      b_mag = b_neg ? -f_q.src2 : f_q.src2;

      step_r = rem_q;
      step_q = quo_q;
      for (int k = 0; k < DIV_STEP; k++) begin
         step_r = {step_r[XLEN-1:0], step_q[XLEN-1]};
         step_q = {step_q[XLEN-2:0], 1'b0};
         if (step_r >= {1'b0, dvs_q}) begin
            step_r    = step_r - {1'b0, dvs_q};
            step_q[0] = 1'b1;
         end
      end

      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dbz_d   = dbz_q;
      case (state_q)
         DIV_IDLE: if (ex_valid_q && is_div && !ex_flush) begin
            state_d = DIV_BUSY;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dbz_d   = (f_q.src2 == '0);
         end
         DIV_BUSY: if (ex_flush) state_d = DIV_IDLE;
         else begin
            rem_d = step_r;
            quo_d = step_q;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(STEPS-1)) state_d = DIV_DONE;
         end
         DIV_DONE: if (ex_flush || (ex_to_mem_valid && mem_allowin)) state_d = DIV_IDLE;
         default: state_d = DIV_IDLE;
      endcase

      // min / -1 falls out naturally: |min| negated is min again
      if (f_q.md_op[1]) div_res = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
      else if (dbz_q)   div_res = '1;
      else              div_res = qneg_q ? -quo_q : quo_q;
   end

   // ---------------- memory request ----------------
   always_comb begin
      case (f_q.size)
         2'd0:    mis = 1'b0;
         2'd1:    mis = alu_res[0];
         2'd2:    mis = |alu_res[1:0];
         default: mis = (XLEN == 32) ? 1'b1 : |alu_res[2:0];
      endcase
      ale_raw = (is_ld | is_st) & mis;

      case (f_q.size)
         2'd0:    we_base = NB'(1);
         2'd1:    we_base = NB'(3);
         2'd2:    we_base = NB'(15);
         default: we_base = '1;
      endcase
      st_mask = we_base << alu_res[LB-1:0];

      case (f_q.size)
         2'd0:    st_wdata = {NB{f_q.rkd[7:0]}};
         2'd1:    st_wdata = {(XLEN/16){f_q.rkd[15:0]}};
         2'd2:    st_wdata = {(XLEN/32){f_q.rkd[31:0]}};
         default: st_wdata = f_q.rkd;
      endcase
   end

   // ---------------- outputs, all gated by ex_valid ----------------
   always_comb begin
      sel_res         = is_div ? div_res : (is_mul ? mul_res : alu_res);
      ex_pc           = ex_valid_q ? f_q.pc : '0;
      ex_result       = ex_valid_q ? sel_res : '0;
      ex_rf_we        = ex_valid_q & f_q.rf_we & ~ale_raw;
      ex_rf_waddr     = ex_valid_q ? f_q.rf_waddr : 5'd0;
      ex_is_load      = ex_valid_q & is_ld;
      ex_ale          = ex_valid_q & ale_raw;
      ex_fwd_we       = ex_rf_we;
      ex_fwd_addr     = ex_rf_waddr;
      ex_fwd_ready    = ~(ex_valid_q & (is_ld | (is_div & (state_q != DIV_DONE))));
      data_sram_en    = ex_valid_q & (is_ld | is_st) & ~ale_raw & ~ex_flush;
      data_sram_we    = (data_sram_en & is_st) ? st_mask : '0;
      data_sram_addr  = ex_valid_q ? alu_res : '0;
      data_sram_wdata = ex_valid_q ? st_wdata : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid_q <= 1'b0;
         f_q        <= '0;
         state_q    <= DIV_IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         ex_valid_q <= ex_valid_d;
         f_q        <= f_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         qneg_q     <= qneg_d;
         rneg_q     <= rneg_d;
         dbz_q      <= dbz_d;
      end
   end
endmodule
